otter_lsu: RTL and testbench
============================

Name: otter_lsu

Overview:
- Load/store initiator for the OTTER MEM stage. It drives the data port (port 2) of the byte-addressable dual-port memory and owns all sub-word and misaligned handling the memory does not support.
- Non-crossing accesses pass through in one cycle.
- Word-boundary-crossing loads become two aligned word reads plus local merge/extend.
- Word-boundary-crossing stores become a sequence of byte stores. The pipeline is stalled while the split completes.

Parameters:
IO_BASE, 32'h11000000, addresses >= this are MMIO; never split.

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous, active-high reset
req_valid  in  1  MEM-stage load/store request; held stable while stall=1
req_we  in  1  1=store, 0=load
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
req_size  in  2  0=byte, 1=half, 2=word (func3[1:0]); 3 illegal, treated as word
req_unsigned  in  1  func3[2]; 1 = zero-extend load
stall  out  1  hold MEM stage (and upstream)
rsp_valid  out  1  load data valid, exactly 1 cycle after acceptance
rsp_rdata  out  32  extended load data
err  out  1  1-cycle pulse: crossing access to MMIO (dropped)
MEM_ADDR2  out  32  memory data-port address
MEM_DIN2  out  32  memory write data
MEM_WRITE2  out  1  memory write enable
MEM_READ2  out  1  memory read enable
MEM_SIZE  out  2  memory access size
MEM_SIGN  out  1  memory unsigned flag
MEM_DOUT2  in  32  memory read data, valid 1 cycle after MEM_READ2

Behaviour:
- Reset:
  - state=IDLE.
  - stall, rsp_valid, err = 0; rsp_rdata=0; lo_word, byte counter = 0.
  - MEM_READ2/MEM_WRITE2 = 0.
- Acceptance: req_valid && !stall at a rising edge.
- Offset off=req_addr[1:0]; nbytes=1/2/4 by size.
- Crossing = off+nbytes > 4, i.e. half@3 or word@1..3.
- IDLE, non-crossing (or !req_valid):
  - MEM_* driven combinationally from req_*: MEM_ADDR2=req_addr, MEM_SIZE=req_size, MEM_SIGN=req_unsigned, MEM_DIN2=req_wdata, MEM_READ2=req_valid&!req_we, MEM_WRITE2=req_valid&req_we.
  - stall=0.
  - Load response: rsp_valid=1 next cycle, rsp_rdata=MEM_DOUT2 (memory slices/extends).
- Crossing load, IDLE cycle 0:
  - Issue word read at {addr[31:2],2'b00}; MEM_SIZE=2, MEM_SIGN=0; stall=1.
  - Next state LD_HI.
- LD_HI (cycle 1):
  - lo_word<=MEM_DOUT2.
  - Issue word read at aligned addr+4; stall=0 (request accepted); next state IDLE.
  - Set registered merge flag, saved off/size/unsigned.
- Cycle 2:
  - rsp_valid=1.
  - rsp_rdata = ({MEM_DOUT2,lo_word} >> 8*off), truncated to 16/32 bits, sign- or zero-extended per saved unsigned.
  - A new request may be issued in this same cycle (port free); its response arrives cycle 3.
- Crossing store:
  - ST_BYTE state with counter k=0..nbytes-1, starting in the IDLE cycle (k=0).
  - Each cycle: MEM_WRITE2=1, MEM_SIZE=0, MEM_ADDR2=req_addr+k, MEM_DIN2[7:0]=req_wdata[8k+7:8k].
  - stall=1 while k<nbytes-1; stall=0 on the last byte; then IDLE.
  - Total cycles = nbytes (half@3: 2, word: 4).
- MMIO (req_addr >= IO_BASE):
  - Non-crossing passes through.
  - Crossing: no MEM_READ2/WRITE2, err=1 for one cycle, stall=0.
  - Loads still give rsp_valid next cycle with rsp_rdata=0.
- Address +4 / +k: 32-bit wrap-around (0xFFFFFFFE+4 wraps to 0x2); no special handling.
- req_valid dropped while stall=1: protocol violation, no defined behaviour required.
- Reset mid-sequence: immediate return to IDLE, outputs to reset values; bytes already written remain written; no response for an interrupted load.
- rsp_valid/err are single-cycle pulses; no back-pressure on responses.

Decomposition:
- Package otter_lsu_pkg:
  - size enum (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2)
  - state enum (IDLE, LD_HI, ST_BYTE)
  - IO_BASE default
  - function crosses(off,size)
- Sub-module otter_load_merge: combinational; {hi,lo}, off, size, unsigned -> extended 32-bit data. Reused if MMIO merge is added later.

Test Plan:
- Memory 0x100=0x44332211, 0x104=0x88776655. lw 0x100 -> no stall, MEM_ADDR2=0x100, MEM_SIZE=2, next cycle rsp_valid=1, rsp_rdata=0x44332211.
- lw 0x101 -> stall=1 one cycle; reads issued 0x100 then 0x104; rsp cycle 2 = 0x55443322. Back-to-back lb 0x104 issued in cycle 2 -> rsp cycle 3 = 0x00000055.
- Set 0x104=0x000000F0. lh 0x103 -> 0xFFFFF044; lhu 0x103 -> 0x0000F044; 1 stall cycle each.
- sw 0x106 data 0xAABBCCDD -> sb 0x106=DD, 0x107=CC, 0x108=BB, 0x109=AA; stall high 3 cycles. Then lw 0x104 = 0xCCDD00F0 and lhu 0x108 = 0x0000AABB.
- lw 0x11000002 -> err pulse, MEM_READ2=0, stall=0, rsp_valid next cycle with 0. Aligned lw 0x11000000 -> MEM_READ2=1, passes through.
- sw 0x201 data 0x01020304 with RST asserted after 2 byte writes -> stall/MEM_WRITE2 drop immediately, state IDLE; only 0x201=04, 0x202=03 written.

Source files
------------

// File: rtl/otter_lsu_pkg.sv
// Shared types and helpers for the OTTER load/store unit.
package otter_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    LD_HI,
    ST_BYTE
  } state_e;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h1100_0000;

  // True when the access spills past the end of its aligned word; size 3 acts as word.
  function automatic logic crosses(input logic [1:0] off, input logic [1:0] size);
    case (size)
      SZ_BYTE: crosses = 1'b0;
      SZ_HALF: crosses = (off == 2'd3);
      default: crosses = (off != 2'd0);
    endcase
  endfunction

  function automatic logic [1:0] last_byte(input logic [1:0] size);
    last_byte = (size == SZ_HALF) ? 2'd1 : 2'd3;
  endfunction

endpackage

// File: rtl/otter_load_merge.sv
// Combines two adjacent aligned words into one misaligned, extended load result.
module otter_load_merge
  import otter_lsu_pkg::*;
(
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);

  logic [63:0] pair;
  logic [31:0] sh;

  always_comb begin
    pair = {hi, lo};
    sh   = pair[{off, 3'b000} +: 32];
    case (size)
      SZ_BYTE: data = {{24{~uns & sh[7]}}, sh[7:0]};
      SZ_HALF: data = {{16{~uns & sh[15]}}, sh[15:0]};
      default: data = sh;
    endcase
  end

endmodule

// File: rtl/otter_lsu.sv
// MEM-stage load/store initiator: splits word-crossing accesses for the data port.
module otter_lsu
  import otter_lsu_pkg::*;
#(
  parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        err,
  output logic [31:0] MEM_ADDR2,
  output logic [31:0] MEM_DIN2,
  output logic        MEM_WRITE2,
  output logic        MEM_READ2,
  output logic [1:0]  MEM_SIZE,
  output logic        MEM_SIGN,
  input  logic [31:0] MEM_DOUT2
);

  state_e      state;
  logic [1:0]  cnt;
  logic [31:0] lo_word;
  logic        merge;
  logic        zero_rsp;
  logic [1:0]  sv_off;
  logic [1:0]  sv_size;
  logic        sv_uns;

  logic [1:0]  off;
  logic        is_cross;
  logic        is_mmio;
  logic [1:0]  last_k;
  logic [31:0] aligned;
  logic [31:0] merged;

  assign off      = req_addr[1:0];
  assign is_cross = crosses(off, req_size);
  assign is_mmio  = (req_addr >= IO_BASE);
  assign last_k   = last_byte(req_size);
  assign aligned  = {req_addr[31:2], 2'b00};

  otter_load_merge u_merge (
    .hi   (MEM_DOUT2),
    .lo   (lo_word),
    .off  (sv_off),
    .size (sv_size),
    .uns  (sv_uns),
    .data (merged)
  );

  // Enables and stall are gated by RST so an in-flight split stops driving the port at once.
  always_comb begin
    MEM_ADDR2  = req_addr;
    MEM_SIZE   = req_size;
    MEM_SIGN   = req_unsigned;
    MEM_DIN2   = req_wdata;
    MEM_READ2  = 1'b0;
    MEM_WRITE2 = 1'b0;
    stall      = 1'b0;
    if (!RST) begin
      case (state)
        IDLE: begin
          if (!is_cross) begin
            MEM_READ2  = req_valid & ~req_we;
            MEM_WRITE2 = req_valid & req_we;
          end else if (req_valid && !is_mmio) begin
            stall = 1'b1;
            if (!req_we) begin
              MEM_ADDR2 = aligned;
              MEM_SIZE  = SZ_WORD;
              MEM_SIGN  = 1'b0;
              MEM_READ2 = 1'b1;
            end else begin
              MEM_SIZE   = SZ_BYTE;
              MEM_SIGN   = 1'b0;
              MEM_DIN2   = {24'h0, req_wdata[7:0]};
              MEM_WRITE2 = 1'b1;
            end
          end
        end
        LD_HI: begin
          MEM_ADDR2 = aligned + 32'd4;
          MEM_SIZE  = SZ_WORD;
          MEM_SIGN  = 1'b0;
          MEM_READ2 = 1'b1;
        end
        ST_BYTE: begin
          MEM_ADDR2  = req_addr + {30'h0, cnt};
          MEM_SIZE   = SZ_BYTE;
          MEM_SIGN   = 1'b0;
          MEM_DIN2   = {24'h0, req_wdata[{cnt, 3'b000} +: 8]};
          MEM_WRITE2 = 1'b1;
          stall      = (cnt != last_k);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    if (merge)
      rsp_rdata = merged;
    else if (rsp_valid && !zero_rsp)
      rsp_rdata = MEM_DOUT2;
    else
      rsp_rdata = '0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      lo_word   <= '0;
      merge     <= 1'b0;
      zero_rsp  <= 1'b0;
      sv_off    <= '0;
      sv_size   <= '0;
      sv_uns    <= 1'b0;
      rsp_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      err       <= 1'b0;
      merge     <= 1'b0;
      zero_rsp  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (!is_cross) begin
              rsp_valid <= ~req_we;
            end else if (is_mmio) begin
              err       <= 1'b1;
              rsp_valid <= ~req_we;
              zero_rsp  <= ~req_we;
            end else if (!req_we) begin
              state <= LD_HI;
            end else begin
              state <= ST_BYTE;
              cnt   <= 2'd1;
            end
          end
        end
        LD_HI: begin
          lo_word   <= MEM_DOUT2;
          merge     <= 1'b1;
          rsp_valid <= 1'b1;
          sv_off    <= off;
          sv_size   <= req_size;
          sv_uns    <= req_unsigned;
          state     <= IDLE;
        end
        ST_BYTE: begin
          if (cnt == last_k) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_otter_lsu.sv
// Directed bench for otter_lsu with a byte-addressable registered-read memory model.
module tb_otter_lsu;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        err;
  logic [31:0] MEM_ADDR2;
  logic [31:0] MEM_DIN2;
  logic        MEM_WRITE2;
  logic        MEM_READ2;
  logic [1:0]  MEM_SIZE;
  logic        MEM_SIGN;
  logic [31:0] MEM_DOUT2;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [0:4095];

  otter_lsu #(.IO_BASE(32'h1100_0000)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .stall        (stall),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .err          (err),
    .MEM_ADDR2    (MEM_ADDR2),
    .MEM_DIN2     (MEM_DIN2),
    .MEM_WRITE2   (MEM_WRITE2),
    .MEM_READ2    (MEM_READ2),
    .MEM_SIZE     (MEM_SIZE),
    .MEM_SIGN     (MEM_SIGN),
    .MEM_DOUT2    (MEM_DOUT2)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic [1:0] sz, input logic uns);
    logic [11:0] i;
    logic [31:0] w;
    i = a[11:0];
    w = {mem[i + 12'd3], mem[i + 12'd2], mem[i + 12'd1], mem[i]};
    case (sz)
      2'd0: mem_rd = {{24{~uns & w[7]}}, w[7:0]};
      2'd1: mem_rd = {{16{~uns & w[15]}}, w[15:0]};
      default: mem_rd = w;
    endcase
  endfunction

  always @(posedge CLK) begin
    logic [11:0] i;
    i = MEM_ADDR2[11:0];
    if (MEM_READ2) MEM_DOUT2 <= mem_rd(MEM_ADDR2, MEM_SIZE, MEM_SIGN);
    if (MEM_WRITE2) begin
      mem[i] <= MEM_DIN2[7:0];
      if (MEM_SIZE != 2'd0) mem[i + 12'd1] <= MEM_DIN2[15:8];
      if (MEM_SIZE[1] || MEM_SIZE == 2'd3) begin
        mem[i + 12'd2] <= MEM_DIN2[23:16];
        mem[i + 12'd3] <= MEM_DIN2[31:24];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issues one request, counts stall cycles until acceptance, returns next-cycle response.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns,
                        output int stalls, output logic rv, output logic [31:0] rd);
    @(posedge CLK); #1;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    req_size = size; req_unsigned = uns;
    stalls = 0;
    @(negedge CLK);
    while (stall && stalls < 8) begin
      stalls++;
      @(posedge CLK); #1;
      @(negedge CLK);
    end
    @(posedge CLK); #1;
    req_valid = 1'b0; req_we = 1'b0;
    @(negedge CLK);
    rv = rsp_valid;
    rd = rsp_rdata;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    int          exp_stalls;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [17];

  initial begin
    int          st;
    logic        rv;
    logic [31:0] rd;

    vecs[0]  = '{1'b0, 32'h100, 32'h0,        2'd2, 1'b0, 0, 32'h44332211};
    vecs[1]  = '{1'b0, 32'h107, 32'h0,        2'd0, 1'b0, 0, 32'hFFFFFF88};
    vecs[2]  = '{1'b0, 32'h102, 32'h0,        2'd1, 1'b1, 0, 32'h00004433};
    vecs[3]  = '{1'b1, 32'h104, 32'h000000F0, 2'd2, 1'b0, 0, 32'h0};
    vecs[4]  = '{1'b0, 32'h103, 32'h0,        2'd1, 1'b0, 1, 32'hFFFFF044};
    vecs[5]  = '{1'b0, 32'h103, 32'h0,        2'd1, 1'b1, 1, 32'h0000F044};
    vecs[6]  = '{1'b1, 32'h106, 32'hAABBCCDD, 2'd2, 1'b0, 3, 32'h0};
    vecs[7]  = '{1'b0, 32'h104, 32'h0,        2'd2, 1'b0, 0, 32'hCCDD00F0};
    vecs[8]  = '{1'b0, 32'h108, 32'h0,        2'd1, 1'b1, 0, 32'h0000AABB};
    vecs[9]  = '{1'b0, 32'h103, 32'h0,        2'd2, 1'b0, 1, 32'hDD00F044};
    vecs[10] = '{1'b1, 32'h10B, 32'h00001234, 2'd1, 1'b0, 1, 32'h0};
    vecs[11] = '{1'b0, 32'h108, 32'h0,        2'd2, 1'b0, 0, 32'h3400AABB};
    vecs[12] = '{1'b0, 32'h10A, 32'h0,        2'd2, 1'b0, 1, 32'h00123400};
    vecs[13] = '{1'b0, 32'h109, 32'h0,        2'd0, 1'b0, 0, 32'hFFFFFFAA};
    vecs[14] = '{1'b0, 32'h109, 32'h0,        2'd0, 1'b1, 0, 32'h000000AA};
    vecs[15] = '{1'b0, 32'h10B, 32'h0,        2'd1, 1'b1, 1, 32'h00001234};
    vecs[16] = '{1'b0, 32'h101, 32'h0,        2'd3, 1'b0, 1, 32'hF0443322};

    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    {mem[3], mem[2], mem[1], mem[0]} = 32'hDEADBEEF;
    {mem['h103], mem['h102], mem['h101], mem['h100]} = 32'h44332211;
    {mem['h107], mem['h106], mem['h105], mem['h104]} = 32'h88776655;

    RST = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_size = '0; req_unsigned = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_rd_wr", {30'h0, MEM_READ2, MEM_WRITE2}, 32'h0);
    @(posedge CLK); #1;
    RST = 1'b0;

    // Aligned load passes straight through.
    @(posedge CLK); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100; req_size = 2'd2; req_unsigned = 1'b0;
    @(negedge CLK);
    chk("lw_stall", {31'h0, stall}, 32'h0);
    chk("lw_addr", MEM_ADDR2, 32'h100);
    chk("lw_size", {30'h0, MEM_SIZE}, 32'h2);
    chk("lw_read", {31'h0, MEM_READ2}, 32'h1);
    @(posedge CLK); #1;
    req_valid = 1'b0;
    @(negedge CLK);
    chk("lw_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    chk("lw_rdata", rsp_rdata, 32'h44332211);

    // Crossing load followed by a back-to-back byte load in the response cycle.
    @(posedge CLK); #1;
    req_valid = 1'b1; req_addr = 32'h101; req_size = 2'd2;
    @(negedge CLK);
    chk("xld_c0_stall", {31'h0, stall}, 32'h1);
    chk("xld_c0_addr", MEM_ADDR2, 32'h100);
    chk("xld_c0_size", {30'h0, MEM_SIZE}, 32'h2);
    chk("xld_c0_read", {31'h0, MEM_READ2}, 32'h1);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("xld_c1_stall", {31'h0, stall}, 32'h0);
    chk("xld_c1_addr", MEM_ADDR2, 32'h104);
    chk("xld_c1_read", {31'h0, MEM_READ2}, 32'h1);
    chk("xld_c1_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    @(posedge CLK); #1;
    req_addr = 32'h104; req_size = 2'd0;
    @(negedge CLK);
    chk("xld_c2_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    chk("xld_c2_rdata", rsp_rdata, 32'h55443322);
    chk("b2b_c2_addr", MEM_ADDR2, 32'h104);
    chk("b2b_c2_read", {31'h0, MEM_READ2}, 32'h1);
    @(posedge CLK); #1;
    req_valid = 1'b0;
    @(negedge CLK);
    chk("b2b_c3_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    chk("b2b_c3_rdata", rsp_rdata, 32'h00000055);

    for (int i = 0; i < 17; i++) begin
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].uns, st, rv, rd);
      chk($sformatf("vec%0d_stalls", i), st, vecs[i].exp_stalls);
      chk($sformatf("vec%0d_rsp_valid", i), {31'h0, rv}, {31'h0, ~vecs[i].we});
      if (!vecs[i].we) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
    end
    chk("sw_split_bytes", {mem['h109], mem['h108], mem['h107], mem['h106]}, 32'hAABBCCDD);

    // Crossing MMIO load is dropped with an error and a zero response.
    @(posedge CLK); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h1100_0002; req_size = 2'd2;
    @(negedge CLK);
    chk("mmio_x_read", {31'h0, MEM_READ2}, 32'h0);
    chk("mmio_x_stall", {31'h0, stall}, 32'h0);
    @(posedge CLK); #1;
    req_valid = 1'b0;
    @(negedge CLK);
    chk("mmio_x_err", {31'h0, err}, 32'h1);
    chk("mmio_x_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    chk("mmio_x_rdata", rsp_rdata, 32'h0);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("mmio_x_err_pulse", {31'h0, err}, 32'h0);

    @(posedge CLK); #1;
    req_valid = 1'b1; req_addr = 32'h1100_0000;
    @(negedge CLK);
    chk("mmio_al_read", {31'h0, MEM_READ2}, 32'h1);
    @(posedge CLK); #1;
    req_valid = 1'b0;
    @(negedge CLK);
    chk("mmio_al_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("mmio_al_err", {31'h0, err}, 32'h0);

    @(posedge CLK); #1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h1100_0001; req_wdata = 32'h12345678;
    @(negedge CLK);
    chk("mmio_xs_write", {31'h0, MEM_WRITE2}, 32'h0);
    @(posedge CLK); #1;
    req_valid = 1'b0; req_we = 1'b0;
    @(negedge CLK);
    chk("mmio_xs_err", {31'h0, err}, 32'h1);
    chk("mmio_xs_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("mmio_xs_mem", {24'h0, mem[1]}, 32'h000000BE);

    // Reset after two of four byte writes of a split store.
    @(posedge CLK); #1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h201; req_wdata = 32'h01020304; req_size = 2'd2;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b1;
    #1;
    chk("rst_mid_stall", {31'h0, stall}, 32'h0);
    chk("rst_mid_write", {31'h0, MEM_WRITE2}, 32'h0);
    req_valid = 1'b0; req_we = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_mid_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_mid_mem", {mem['h204], mem['h203], mem['h202], mem['h201]}, 32'h00000304);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
